// File: rtl/updown_dir_ctrl_if.sv
// Bundle of request, feedback and direction signals between the button/counter
// side (master) and the direction controller (slave).
interface updown_dir_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             up_req;
   logic             dn_req;
   logic             auto_en;
   logic [WIDTH-1:0] count;
   logic             mode;
   logic             dir_chg;

   modport master (
      output up_req, dn_req, auto_en, count,
      input  mode, dir_chg
   );

   modport slave (
      input  up_req, dn_req, auto_en, count,
      output mode, dir_chg
   );
endinterface

// File: rtl/updown_dir_ctrl.sv
// Direction controller for the up/down counter: debounced button requests plus
// optional ping-pong reversal at the count limits, producing a registered mode.
module updown_dir_ctrl #(
   parameter int WIDTH      = 4,
   parameter int DEB_CYCLES = 4,
   parameter int MAX_VAL    = 15,
   parameter int MIN_VAL    = 0
) (
   input  logic             clk,
   input  logic             rst,
   updown_dir_ctrl_if.slave bus
);
   localparam int               CNT_W    = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] HI_THR   = WIDTH'(MAX_VAL - 1);
   localparam logic [WIDTH-1:0] LO_THR   = WIDTH'(MIN_VAL + 1);

   typedef enum logic {
      S_UP   = 1'b0,
      S_DOWN = 1'b1
   } state_t;

   // Index 0 carries the up request, index 1 the down request.
   logic [1:0]            s1_q, s1_d;
   logic [1:0]            s2_q, s2_d;
   logic [1:0]            deb_q, deb_d;
   logic [1:0]            deb_prev_q, deb_prev_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   state_t                state_q, state_d;
   logic                  dir_chg_q, dir_chg_d;
   logic                  up_ev, dn_ev;

   always_comb begin
      s1_d       = {bus.dn_req, bus.up_req};
      s2_d       = s1_q;
      deb_prev_d = deb_q;
      deb_d      = deb_q;
      cnt_d      = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   assign up_ev = deb_q[0] & ~deb_prev_q[0];
   assign dn_ev = deb_q[1] & ~deb_prev_q[1];

   // Thresholds sit one count inside the limits so the registered mode lands
   // exactly when the counter reaches the limit.
   always_comb begin
      state_d = state_q;
      if (up_ev && dn_ev) begin
         state_d = state_q;
      end else if (up_ev) begin
         state_d = S_UP;
      end else if (dn_ev) begin
         state_d = S_DOWN;
      end else if (bus.auto_en && (state_q == S_UP) && (bus.count >= HI_THR)) begin
         state_d = S_DOWN;
      end else if (bus.auto_en && (state_q == S_DOWN) && (bus.count <= LO_THR)) begin
         state_d = S_UP;
      end
      dir_chg_d = (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         cnt_q      <= '0;
         state_q    <= S_UP;
         dir_chg_q  <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         dir_chg_q  <= dir_chg_d;
      end
   end

   assign bus.mode    = state_q;
   assign bus.dir_chg = dir_chg_q;
endmodule
